// File: rtl/multicycle_responder_pkg.sv
// Shared definitions for the request/devwait stall-protocol responder:
// state encoding and default timeout sizing.
package multicycle_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 64;
  localparam int unsigned DEFAULT_CNTW    = 7;

endpackage

// File: rtl/multicycle_responder_timeout_counter.sv
// Clearable up-counter with a terminal-count flag; used to bound how long a
// stall-protocol device waits on its backend.
module responder_timeout_counter #(
  parameter int unsigned CNTW     = 7,
  parameter int unsigned TERMINAL = 63
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNTW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == CNTW'(TERMINAL));

endmodule

// File: rtl/multicycle_responder.sv
// Device side of the request/devwait stall protocol: launches a backend
// operation, holds the requester stalled, and releases it for one cycle.
module multicycle_responder
  import multicycle_responder_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CTLW    = 4,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNTW    = DEFAULT_CNTW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             request,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [CTLW-1:0]  op_ctl,
  output logic             devwait,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             be_start,
  output logic [WIDTH-1:0] be_a,
  output logic [WIDTH-1:0] be_b,
  output logic [CTLW-1:0]  be_ctl,
  output logic             be_abort,
  input  logic             be_done,
  input  logic [WIDTH-1:0] be_result
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             be_start_q, be_start_d;
  logic             be_abort_q, be_abort_d;
  logic [WIDTH-1:0] be_a_q, be_a_d;
  logic [WIDTH-1:0] be_b_q, be_b_d;
  logic [CTLW-1:0]  be_ctl_q, be_ctl_d;
  logic             cnt_clr, cnt_en, timeout_tc;

  responder_timeout_counter #(
    .CNTW     (CNTW),
    .TERMINAL (TIMEOUT - 1)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (timeout_tc)
  );

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    err_d      = err_q;
    be_a_d     = be_a_q;
    be_b_d     = be_b_q;
    be_ctl_d   = be_ctl_q;
    be_start_d = 1'b0;
    be_abort_d = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (request) begin
          be_a_d     = op_a;
          be_b_d     = op_b;
          be_ctl_d   = op_ctl;
          be_start_d = 1'b1;
          cnt_clr    = 1'b1;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_en = 1'b1;
        // A withdrawn request beats both completion and timeout; only a
        // still-running backend needs draining.
        if (!request) begin
          if (be_done) begin
            state_d = ST_IDLE;
          end else if (timeout_tc) begin
            be_abort_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (be_done) begin
          result_d = be_result;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (timeout_tc) begin
          result_d   = '0;
          err_d      = 1'b1;
          be_abort_d = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        cnt_en = 1'b1;
        if (be_done) begin
          state_d = ST_IDLE;
        end else if (timeout_tc) begin
          be_abort_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      err_q      <= 1'b0;
      be_start_q <= 1'b0;
      be_abort_q <= 1'b0;
      be_a_q     <= '0;
      be_b_q     <= '0;
      be_ctl_q   <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      err_q      <= err_d;
      be_start_q <= be_start_d;
      be_abort_q <= be_abort_d;
      be_a_q     <= be_a_d;
      be_b_q     <= be_b_d;
      be_ctl_q   <= be_ctl_d;
    end
  end

  assign devwait  = (state_q != ST_RESP);
  assign result   = result_q;
  assign err      = err_q;
  assign be_start = be_start_q;
  assign be_abort = be_abort_q;
  assign be_a     = be_a_q;
  assign be_b     = be_b_q;
  assign be_ctl   = be_ctl_q;

endmodule

// File: tb/tb_multicycle_responder.sv
// Bench for multicycle_responder: directed protocol scenarios plus random
// traffic, checked every cycle against a transaction-level model.
module tb_multicycle_responder;

  localparam int WIDTH   = 32;
  localparam int CTLW    = 4;
  localparam int TIMEOUT = 64;
  localparam int CNTW    = 7;

  logic             clk = 1'b0;
  logic             reset, request, be_done;
  logic [WIDTH-1:0] op_a, op_b, be_result;
  logic [CTLW-1:0]  op_ctl;
  logic             devwait, err, be_start, be_abort;
  logic [WIDTH-1:0] result, be_a, be_b;
  logic [CTLW-1:0]  be_ctl;

  multicycle_responder #(
    .WIDTH(WIDTH), .CTLW(CTLW), .TIMEOUT(TIMEOUT), .CNTW(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .request(request),
    .op_a(op_a), .op_b(op_b), .op_ctl(op_ctl),
    .devwait(devwait), .result(result), .err(err),
    .be_start(be_start), .be_a(be_a), .be_b(be_b), .be_ctl(be_ctl),
    .be_abort(be_abort), .be_done(be_done), .be_result(be_result)
  );

  always #5 clk = ~clk;

  // Model of one outstanding operation: live (requester still waiting),
  // orphan (requester gave up, backend still running), release_now (the one
  // devwait-low cycle). elapsed counts backend cycles since the launch edge.
  typedef struct {
    bit          live;
    bit          orphan;
    bit          release_now;
    int          elapsed;
    logic [31:0] res;
    logic        err;
    logic        start;
    logic        abort;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
  } model_t;

  model_t m;
  int     nvec = 0;
  int     nmis = 0;
  bit     chk_en = 1'b0;

  function automatic model_t model_next(model_t s);
    model_t n = s;
    bit     expired;
    n.start = 1'b0;
    n.abort = 1'b0;
    if (reset) begin
      n = '{default: 0};
      return n;
    end
    if (s.release_now) begin
      n.release_now = 1'b0;
    end else if (!s.live && !s.orphan) begin
      if (request) begin
        n.live = 1'b1; n.elapsed = 1; n.start = 1'b1;
        n.a = op_a; n.b = op_b; n.ctl = op_ctl;
      end
    end else begin
      expired   = (s.elapsed == TIMEOUT);
      n.elapsed = s.elapsed + 1;
      if (s.orphan) begin
        if (be_done) n.orphan = 1'b0;
        else if (expired) begin n.orphan = 1'b0; n.abort = 1'b1; end
      end else if (!request) begin
        n.live   = 1'b0;
        n.orphan = !be_done && !expired;
        n.abort  = !be_done && expired;
      end else if (be_done) begin
        n.live = 1'b0; n.release_now = 1'b1; n.res = be_result; n.err = 1'b0;
      end else if (expired) begin
        n.live = 1'b0; n.release_now = 1'b1; n.res = '0; n.err = 1'b1;
        n.abort = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    chk(name, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      nvec++;
      chk("devwait",  32'(devwait),  32'(!m.release_now));
      chk("result",   result,        m.res);
      chk("err",      32'(err),      32'(m.err));
      chk("be_start", 32'(be_start), 32'(m.start));
      chk("be_abort", 32'(be_abort), 32'(m.abort));
      chk("be_a",     be_a,          m.a);
      chk("be_b",     be_b,          m.b);
      chk("be_ctl",   32'(be_ctl),   32'(m.ctl));
    end
  end

  task automatic step(input logic r, input logic d, input logic [31:0] res);
    request   = r;
    be_done   = d;
    be_result = res;
    @(negedge clk);
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    op_a = a; op_b = b; op_ctl = c;
  endtask

  initial begin
    int hi;
    int busy;
    int pdone;
    int preq;
    reset = 1'b1; request = 1'b0; be_done = 1'b0; be_result = '0;
    set_ops(0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    lit("rst_devwait", 32'(devwait), 1);
    lit("rst_result", result, 0);
    lit("rst_be_start", 32'(be_start), 0);
    reset = 1'b0;

    // Minimum-latency operation
    set_ops(5, 7, 3);
    step(1, 0, 0);
    lit("min_start", 32'(be_start), 1);
    lit("min_stall", 32'(devwait), 1);
    lit("min_be_a", be_a, 5);
    lit("min_be_b", be_b, 7);
    step(1, 1, 35);
    lit("min_release", 32'(devwait), 0);
    lit("min_result", result, 35);
    lit("min_err", 32'(err), 0);
    step(0, 0, 0);
    lit("min_idle", 32'(devwait), 1);
    lit("min_hold", result, 35);

    // Ten-cycle backend
    set_ops(32'h1111, 32'h2222, 4'h9);
    step(1, 0, 0);
    hi = (devwait === 1'b1) ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 0);
      if (devwait === 1'b1) hi++;
    end
    lit("lat10_stall", 32'(hi + 1), 11);
    step(1, 1, 32'hDEADBEEF);
    lit("lat10_release", 32'(devwait), 0);
    lit("lat10_result", result, 32'hDEADBEEF);
    step(0, 0, 0);

    // Silent backend: timeout
    set_ops(32'hA, 32'hB, 4'hC);
    step(1, 0, 0);
    busy = 0;
    while (devwait === 1'b1 && busy < 200) begin
      busy++;
      step(1, 0, 0);
    end
    lit("to_busy_cycles", 32'(busy), 64);
    lit("to_err", 32'(err), 1);
    lit("to_result", result, 0);
    lit("to_abort", 32'(be_abort), 1);
    step(0, 1, 32'hABCD);
    lit("to_abort_single", 32'(be_abort), 0);
    lit("to_late_done", result, 0);
    step(0, 1, 32'hABCD);
    lit("to_late_err", 32'(err), 1);

    // Squash into drain, then a request waits out the drain
    set_ops(1, 1, 1);
    step(1, 0, 0);
    step(1, 1, 32'h55AA);
    lit("pre_squash", result, 32'h55AA);
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    lit("drain_stall", 32'(devwait), 1);
    set_ops(11, 13, 2);
    step(1, 0, 0);
    step(1, 0, 0);
    lit("drain_no_start", 32'(be_start), 0);
    step(1, 1, 32'h1234);
    lit("drain_discard", result, 32'h55AA);
    lit("drain_still_stall", 32'(devwait), 1);
    step(1, 0, 0);
    lit("after_drain_start", 32'(be_start), 1);
    lit("after_drain_be_a", be_a, 11);
    step(1, 1, 143);
    lit("after_drain_result", result, 143);

    // Back-to-back operations
    set_ops(2, 3, 1);
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 1, 6);
    lit("b2b_first", result, 6);
    set_ops(4, 5, 2);
    step(1, 0, 0);
    lit("b2b_gap", 32'(devwait), 1);
    lit("b2b_gap_start", 32'(be_start), 0);
    step(1, 0, 0);
    lit("b2b_be_a", be_a, 4);
    lit("b2b_be_ctl", 32'(be_ctl), 2);
    step(1, 1, 20);
    lit("b2b_second", result, 20);
    step(0, 0, 0);

    // Reset in the middle of BUSY
    set_ops(9, 9, 9);
    step(1, 0, 0);
    step(1, 0, 0);
    reset = 1'b1;
    step(1, 1, 32'h777);
    lit("mid_rst_devwait", 32'(devwait), 1);
    lit("mid_rst_result", result, 0);
    lit("mid_rst_be_a", be_a, 0);
    reset = 1'b0;
    step(0, 1, 32'h888);
    lit("post_rst_done", result, 0);
    lit("post_rst_devwait", 32'(devwait), 1);
    step(0, 0, 0);

    // Random traffic in episodes of varying backend and requester behaviour
    pdone = 0; preq = 100;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        case ($urandom_range(0, 2))
          0: pdone = 0;
          1: pdone = 4;
          default: pdone = 40;
        endcase
        case ($urandom_range(0, 2))
          0: preq = 100;
          1: preq = 92;
          default: preq = 60;
        endcase
      end
      reset     = ($urandom_range(0, 499) == 0);
      request   = ($urandom_range(0, 99) < preq);
      be_done   = ($urandom_range(0, 99) < pdone);
      be_result = $urandom;
      op_a      = $urandom;
      op_b      = $urandom;
      op_ctl    = 4'($urandom);
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/multicycle_responder.md
Name: multicycle_responder

Overview:
- Device-side end of the request/devwait multi-cycle stall protocol: accepts a pipeline request and holds devwait high until a result is ready.
- Drives devwait low for exactly one cycle to release the requester, presenting the result in that cycle.
- Sits between a pipeline stage's stall logic and a variable-latency backend unit (start/done handshake), e.g. divider or external memory port.
- Handles squash (request withdrawn mid-operation) and a backend timeout.

Parameters:
- WIDTH, 32, operand/result width
- CTLW, 4, width of operation-control field passed to backend
- TIMEOUT, 64, max BUSY cycles before forced error completion (>=2)
- CNTW, 7, counter width; must hold TIMEOUT

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- request  in  1  requester wants an operation this cycle (held while stalled)
- op_a  in  WIDTH  operand A, valid with request
- op_b  in  WIDTH  operand B, valid with request
- op_ctl  in  CTLW  operation select, valid with request
- devwait  out  1  high = requester stays stalled; low = operation complete
- result  out  WIDTH  operation result, valid when devwait low
- err  out  1  timeout flag, valid when devwait low
- be_start  out  1  one-cycle start pulse to backend
- be_a, be_b  out  WIDTH  latched operands to backend
- be_ctl  out  CTLW  latched control to backend
- be_abort  out  1  one-cycle abort pulse to backend on timeout
- be_done  in  1  backend completion pulse
- be_result  in  WIDTH  backend result, valid with be_done

Behaviour:
- Single clock, synchronous active-high reset; all state updates on posedge clk.
- Reset values: state IDLE, devwait 1, result 0, err 0, be_start 0, be_abort 0, be_a/be_b/be_ctl 0, counter 0. Reset mid-operation returns to IDLE immediately; backend done pulses after reset are ignored.
- States: IDLE, BUSY, RESP, DRAIN.
- devwait is low only in RESP. It is 1 in every other state; the requester ignores it in its first stall cycle.
- IDLE:
  - On request: latch op_a/op_b/op_ctl into be_a/be_b/be_ctl, clear counter, go BUSY.
  - be_start is registered, so it is high in the first BUSY cycle only.
- BUSY:
  - Counter increments each cycle. be_done is sampled in every BUSY cycle, including the be_start cycle.
  - be_done=1: result <= be_result, err <= 0, go RESP.
  - request=0 and be_done=0 (squash): go DRAIN.
  - request=0 and be_done=1 in the same cycle: treat as squash; discard the result and go IDLE.
  - Counter reaches TIMEOUT-1 without be_done: result <= 0, err <= 1, be_abort high for the next cycle, go RESP. Any squash in that same cycle takes priority and the next state is IDLE with be_abort still pulsed.
- RESP:
  - devwait=0 for exactly one cycle; result/err stable; go IDLE unconditionally.
  - A request in the next cycle is a new operation; the requester's stall FSM restarts.
- DRAIN:
  - Wait for be_done, discard be_result, go IDLE.
  - Counter continues; on TIMEOUT-1, pulse be_abort and go IDLE.
  - Requests arriving in DRAIN are not accepted until IDLE; the requester stays stalled because devwait=1.
- result and err hold their value outside RESP until the next capture; they are not cleared.
- Minimum latency: request at cycle k -> BUSY k+1 (be_start) -> RESP k+2 if be_done at k+1. Three cycles request-to-release.
- Back-to-back operations: RESP, then IDLE accepts the next request one cycle later. No bubble beyond IDLE.
- be_done outside BUSY/DRAIN is ignored.

Decomposition:
- Shared package: state encoding constants (IDLE=0, BUSY=1, RESP=2, DRAIN=3) and default TIMEOUT.
- One natural sub-module, responder_timeout_counter: loadable-clear counter with terminal-count output, reusable by other stall-protocol devices.
- The rest is a single FSM plus the operand/result registers.

Test Plan:
- Reset then request with op_a=5, op_b=7, be_done one cycle after be_start with be_result=35 -> be_start at k+1, devwait=1 for k..k+1, devwait=0 at k+2 with result=35, err=0, then IDLE.
- Backend latency 10 cycles, be_result=0xDEADBEEF -> devwait high 11 cycles after request cycle, single low cycle with result 0xDEADBEEF.
- Backend never responds, TIMEOUT=64 -> RESP after 64 BUSY cycles with err=1, result=0, be_abort single pulse; a late be_done is ignored.
- Request dropped 2 cycles into BUSY, be_done 3 cycles later with 0x1234 -> no RESP, result keeps old value. A new request during DRAIN is accepted only after be_done and completes normally.
- Two back-to-back requests with 1-cycle backend -> two single-cycle devwait lows separated by IDLE+BUSY cycles; operands latched correctly for each.
- Reset asserted while BUSY -> next cycle IDLE, devwait=1, be_start=0, result=0, err=0; be_done arriving afterward has no effect.
